// File: rtl/eviction_buffer_ctrl.sv
// Purpose: FIFO-allocated, fully associative victim-line buffer controller with dirty-line drain to memory.
// Latency: accept/merge and lookup are combinational in-cycle; a clean head retires in 1 cycle, a dirty head waits for mem_resp.
// Backpressure: evict_ready drops when the buffer is full and the tag is new, or when the tag is the line being written back.
// Optional: define EVB_STATS_EN to add the saturating stat_drains / stat_hits counters.
module eviction_buffer_ctrl #(
    parameter int SIZE         = 8,
    parameter int DRAIN_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    evict_valid,
    output logic                    evict_ready,
    input  logic [15:0]             evict_addr,
    input  logic                    evict_dirty,
    output logic                    arr_write,
    output logic [$clog2(SIZE)-1:0] arr_index,
    input  logic [15:0]             lookup_addr,
    output logic                    lookup_hit,
    output logic [$clog2(SIZE)-1:0] lookup_index,
    output logic                    mem_write,
    output logic [15:0]             mem_addr,
    input  logic                    mem_resp,
    input  logic                    flush,
    output logic                    flush_done
`ifdef EVB_STATS_EN
    ,
    output logic [15:0]             stat_drains,
    output logic [15:0]             stat_hits
`endif
);

    localparam int IW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic [SIZE-1:0] valid, dirty;
    logic [11:0]     tags [SIZE];

    logic [11:0]     evict_tag, lookup_tag;
    logic            ev_hit;
    logic [IW-1:0]   ev_idx;
    logic            accept, merge, alloc, retire, drain, head_dirty_eff, head_busy;
    logic            unused_low_bits;

    assign evict_tag  = evict_addr[15:4];
    assign lookup_tag = lookup_addr[15:4];
    // Byte offset within the line plays no part in tag matching.
    assign unused_low_bits = ^{evict_addr[3:0], lookup_addr[3:0]};

    // Associative tag match for the incoming victim and for the L1 probe.
    always_comb begin
        ev_hit       = 1'b0;
        ev_idx       = '0;
        lookup_hit   = 1'b0;
        lookup_index = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (valid[i] && tags[i] == evict_tag) begin
                ev_hit = 1'b1;
                ev_idx = IW'(i);
            end
            if (valid[i] && tags[i] == lookup_tag) begin
                lookup_hit   = 1'b1;
                lookup_index = IW'(i);
            end
        end
    end

    // A victim whose tag matches the line being written back must wait, otherwise its data would be lost.
    assign head_busy   = (state == WRITE) && (tags[head] == evict_tag);
    assign evict_ready = ((count < CW'(SIZE)) || ev_hit) && !head_busy;
    assign accept      = evict_valid && evict_ready;
    assign merge       = accept && ev_hit;
    assign alloc       = accept && !ev_hit;

    assign drain = (count != '0) && ((count >= CW'(DRAIN_THRESH)) || flush);
    // A dirty merge landing on a clean head this cycle must not let that head be silently retired.
    assign head_dirty_eff = dirty[head] || (merge && (ev_idx == head) && evict_dirty);
    assign retire = ((state == IDLE) && drain && !head_dirty_eff) ||
                    ((state == WRITE) && mem_resp);

    assign flush_done = flush && (count == '0);

    // Drain FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Drain FSM next state: write back a dirty head, return once memory acknowledges.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (drain && head_dirty_eff) state_nxt = WRITE;
            WRITE:   if (mem_resp)                state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: accepts own arr_index; otherwise it points at the head being drained.
    always_comb begin
        arr_write = accept;
        arr_index = '0;
        mem_write = 1'b0;
        mem_addr  = '0;
        if (merge)              arr_index = ev_idx;
        else if (alloc)         arr_index = tail;
        else if (state == WRITE) arr_index = head;
        if (state == WRITE) begin
            mem_write = 1'b1;
            mem_addr  = {tags[head], 4'b0000};
        end
    end

    // Slot bookkeeping: retire at head, allocate at tail, merge in place; count tracks net change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            dirty <= '0;
            for (int i = 0; i < SIZE; i++) tags[i] <= '0;
        end else begin
            if (retire) begin
                valid[head] <= 1'b0;
                dirty[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (alloc) begin
                valid[tail] <= 1'b1;
                dirty[tail] <= evict_dirty;
                tags[tail]  <= evict_tag;
                tail        <= tail + 1'b1;
            end
            if (merge) dirty[ev_idx] <= dirty[ev_idx] | evict_dirty;
            count <= count + CW'(alloc) - CW'(retire);
        end
    end

`ifdef EVB_STATS_EN
    // Saturating event counters for completed write-backs and hit cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_drains <= '0;
            stat_hits   <= '0;
        end else begin
            if (state == WRITE && mem_resp && stat_drains != 16'hFFFF) stat_drains <= stat_drains + 1'b1;
            if (lookup_hit && stat_hits != 16'hFFFF)                   stat_hits   <= stat_hits + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_eviction_buffer_ctrl.sv
// Bench for eviction_buffer_ctrl: instance A (threshold 4) and instance B (threshold = SIZE).
// Stimulus pushes expected arr_index / mem_addr into queues; a negedge monitor pops and compares.
// Directed checks cover reset, threshold drain, full/merge, write-back blocking, flush and reset mid-write.
module tb_eviction_buffer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        a_evict_valid, a_evict_ready, a_evict_dirty, a_arr_write;
    logic        a_lookup_hit, a_mem_write, a_mem_resp, a_flush, a_flush_done;
    logic [15:0] a_evict_addr, a_lookup_addr, a_mem_addr;
    logic [2:0]  a_arr_index, a_lookup_index;

    logic        b_evict_valid, b_evict_ready, b_evict_dirty, b_arr_write;
    logic        b_lookup_hit, b_mem_write, b_mem_resp, b_flush, b_flush_done;
    logic [15:0] b_evict_addr, b_lookup_addr, b_mem_addr;
    logic [2:0]  b_arr_index, b_lookup_index;

`ifdef EVB_STATS_EN
    logic [15:0] a_stat_drains, a_stat_hits, b_stat_drains, b_stat_hits;
`endif

    eviction_buffer_ctrl #(.SIZE(8), .DRAIN_THRESH(4)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .evict_valid(a_evict_valid), .evict_ready(a_evict_ready),
        .evict_addr(a_evict_addr), .evict_dirty(a_evict_dirty),
        .arr_write(a_arr_write), .arr_index(a_arr_index),
        .lookup_addr(a_lookup_addr), .lookup_hit(a_lookup_hit), .lookup_index(a_lookup_index),
        .mem_write(a_mem_write), .mem_addr(a_mem_addr), .mem_resp(a_mem_resp),
        .flush(a_flush), .flush_done(a_flush_done)
`ifdef EVB_STATS_EN
        , .stat_drains(a_stat_drains), .stat_hits(a_stat_hits)
`endif
    );

    eviction_buffer_ctrl #(.SIZE(8), .DRAIN_THRESH(8)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .evict_valid(b_evict_valid), .evict_ready(b_evict_ready),
        .evict_addr(b_evict_addr), .evict_dirty(b_evict_dirty),
        .arr_write(b_arr_write), .arr_index(b_arr_index),
        .lookup_addr(b_lookup_addr), .lookup_hit(b_lookup_hit), .lookup_index(b_lookup_index),
        .mem_write(b_mem_write), .mem_addr(b_mem_addr), .mem_resp(b_mem_resp),
        .flush(b_flush), .flush_done(b_flush_done)
`ifdef EVB_STATS_EN
        , .stat_drains(b_stat_drains), .stat_hits(b_stat_hits)
`endif
    );

    int total  = 0;
    int passed = 0;

    logic [2:0]  exp_arr_a [$];
    logic [2:0]  exp_arr_b [$];
    logic [15:0] exp_mem_a [$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    endfunction

    function automatic void fail_now(input string nm);
        total++;
        $display("FAIL %s: unexpected event or timeout", nm);
    endfunction

    // Scoreboard monitor: every array write and every completed memory write is checked.
    always @(negedge clk) begin
        if (a_arr_write) begin
            if (exp_arr_a.size() == 0) fail_now("arr_a_unexpected");
            else chk("arr_a_index", 32'(a_arr_index), 32'(exp_arr_a.pop_front()));
        end
        if (b_arr_write) begin
            if (exp_arr_b.size() == 0) fail_now("arr_b_unexpected");
            else chk("arr_b_index", 32'(b_arr_index), 32'(exp_arr_b.pop_front()));
        end
        if (a_mem_write && exp_mem_a.size() == 0) fail_now("mem_a_unexpected");
        else if (a_mem_write && a_mem_resp) chk("mem_a_addr", 32'(a_mem_addr), 32'(exp_mem_a.pop_front()));
    end

    task automatic do_evict(input bit on_b, input logic [15:0] addr, input logic dty, input int idx);
        @(posedge clk); #1;
        if (on_b) begin
            b_evict_valid = 1'b1; b_evict_addr = addr; b_evict_dirty = dty;
            exp_arr_b.push_back(3'(idx));
        end else begin
            a_evict_valid = 1'b1; a_evict_addr = addr; a_evict_dirty = dty;
            exp_arr_a.push_back(3'(idx));
        end
        @(negedge clk);
        chk(on_b ? "b_evict_ready" : "a_evict_ready", 32'(on_b ? b_evict_ready : a_evict_ready), 1);
        @(posedge clk); #1;
        if (on_b) b_evict_valid = 1'b0;
        else      a_evict_valid = 1'b0;
    endtask

    // Wait for a write-back on A, hold mem_resp low for 'hold' cycles checking stability, then acknowledge.
    task automatic serve_a(input logic [15:0] addr, input int head_idx, input int hold, output int waited);
        waited = 0;
        @(negedge clk);
        while (!a_mem_write && waited < 30) begin
            waited++;
            @(negedge clk);
        end
        if (!a_mem_write) begin
            fail_now("mem_a_timeout");
            exp_mem_a.delete();
        end else begin
            for (int i = 0; i < hold; i++) begin
                chk("hold_mem_write", 32'(a_mem_write), 1);
                chk("hold_mem_addr", 32'(a_mem_addr), 32'(addr));
                chk("hold_arr_index", 32'(a_arr_index), 32'(head_idx));
                @(negedge clk);
            end
            @(posedge clk); #1 a_mem_resp = 1'b1;
            @(negedge clk);
            @(posedge clk); #1 a_mem_resp = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset_n = 1'b0;
        a_evict_valid = 0; a_evict_addr = '0; a_evict_dirty = 0; a_lookup_addr = '0; a_mem_resp = 0; a_flush = 0;
        b_evict_valid = 0; b_evict_addr = '0; b_evict_dirty = 0; b_lookup_addr = '0; b_mem_resp = 0; b_flush = 0;

        // Reset state
        @(negedge clk);
        chk("rst_mem_write", 32'(a_mem_write), 0);
        chk("rst_arr_write", 32'(a_arr_write), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rel_evict_ready", 32'(a_evict_ready), 1);
        chk("rel_arr_index", 32'(a_arr_index), 0);
        chk("rel_mem_addr", 32'(a_mem_addr), 0);
        chk("rel_lookup_hit", 32'(a_lookup_hit), 0);
        chk("rel_lookup_index", 32'(a_lookup_index), 0);
        chk("rel_flush_done", 32'(a_flush_done), 0);

        // B: fill 8 (head dirty so it stays in write-back, keeping the buffer full)
        for (int i = 0; i < 8; i++) do_evict(1, 16'h6000 + 16'(i * 16), (i == 0), i);
        b_evict_valid = 1'b1; b_evict_addr = 16'h7000; b_evict_dirty = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("b_full_new_tag_ready", 32'(b_evict_ready), 0);
        end
        do_evict(1, 16'h6030, 1, 3);
        b_evict_addr = 16'h7010;
        @(negedge clk);
        chk("b_still_full_ready", 32'(b_evict_ready), 0);
        chk("b_wb_mem_write", 32'(b_mem_write), 1);
        chk("b_wb_mem_addr", 32'(b_mem_addr), 'h6000);
        chk("b_wb_arr_index", 32'(b_arr_index), 0);
        @(posedge clk); #1 b_mem_resp = 1'b1; b_flush = 1'b1;
        @(posedge clk); #1 b_mem_resp = 1'b0;
        w = 0;
        @(negedge clk);
        while (!b_mem_write && w < 20) begin w++; @(negedge clk); end
        chk("b_merge_dirty_wait", 32'(w), 3);
        chk("b_merge_dirty_addr", 32'(b_mem_addr), 'h6030);
        @(posedge clk); #1 b_mem_resp = 1'b1;
        @(posedge clk); #1 b_mem_resp = 1'b0;
        w = 0;
        @(negedge clk);
        while (!b_flush_done && w < 20) begin w++; @(negedge clk); end
        chk("b_flush_done_wait", 32'(w), 4);
        b_flush = 1'b0;

        // A: three dirty victims stay below threshold
        do_evict(0, 16'h1000, 1, 0);
        do_evict(0, 16'h1010, 1, 1);
        do_evict(0, 16'h1020, 1, 2);
        repeat (3) begin
            @(negedge clk);
            chk("below_thresh_mem_write", 32'(a_mem_write), 0);
        end

        // A: fourth victim reaches threshold, head written back with delayed response
        exp_mem_a.push_back(16'h1000);
        do_evict(0, 16'h1030, 1, 3);
        serve_a(16'h1000, 0, 5, w);
        chk("thresh_write_wait", 32'(w), 1);
        a_lookup_addr = 16'h1000;
        @(negedge clk);
        chk("post_resp_mem_write", 32'(a_mem_write), 0);
        chk("retired_lookup_hit", 32'(a_lookup_hit), 0);
        chk("retired_lookup_index", 32'(a_lookup_index), 0);
        @(posedge clk); #1 a_lookup_addr = 16'h1018;
        @(negedge clk);
        chk("lookup_1010_hit", 32'(a_lookup_hit), 1);
        chk("lookup_1010_index", 32'(a_lookup_index), 1);

        // A: fresh reset, then lookup hit and write-back blocking of the same tag
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        a_lookup_addr = 16'h2008;
        do_evict(0, 16'h2000, 1, 0);
        exp_mem_a.push_back(16'h2000);
        a_flush = 1'b1;
        @(negedge clk);
        chk("lookup_2008_hit", 32'(a_lookup_hit), 1);
        chk("lookup_2008_index", 32'(a_lookup_index), 0);
        @(posedge clk); #1 a_evict_valid = 1'b1; a_evict_addr = 16'h2000; a_evict_dirty = 1'b0;
        @(negedge clk);
        chk("wb_mem_write", 32'(a_mem_write), 1);
        chk("wb_same_tag_ready", 32'(a_evict_ready), 0);
        chk("wb_lookup_hit", 32'(a_lookup_hit), 1);
        @(negedge clk);
        chk("wb_same_tag_ready2", 32'(a_evict_ready), 0);
        @(posedge clk); #1 a_mem_resp = 1'b1; a_evict_valid = 1'b0;
        @(posedge clk); #1 a_mem_resp = 1'b0;
        @(negedge clk);
        chk("after_wb_ready", 32'(a_evict_ready), 1);
        chk("after_wb_flush_done", 32'(a_flush_done), 1);
        chk("after_wb_lookup_hit", 32'(a_lookup_hit), 0);

        // A: flush two dirty + one clean
        @(posedge clk); #1 a_flush = 1'b0;
        do_evict(0, 16'h3000, 1, 1);
        do_evict(0, 16'h3010, 0, 2);
        do_evict(0, 16'h3020, 1, 3);
        exp_mem_a.push_back(16'h3000);
        a_flush = 1'b1;
        serve_a(16'h3000, 1, 1, w);
        chk("flush_first_wait", 32'(w), 1);
        chk("flush_done_mid", 32'(a_flush_done), 0);
        exp_mem_a.push_back(16'h3020);
        serve_a(16'h3020, 3, 1, w);
        chk("flush_clean_retire_wait", 32'(w), 2);
        @(negedge clk);
        chk("flush_done_end", 32'(a_flush_done), 1);

        // A: reset in the middle of a write-back; late response is ignored
        a_lookup_addr = 16'h4000;
        exp_mem_a.push_back(16'h4000);
        do_evict(0, 16'h4000, 1, 4);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_mem_write", 32'(a_mem_write), 1);
        chk("pre_rst_mem_addr", 32'(a_mem_addr), 'h4000);
        chk("pre_rst_lookup_index", 32'(a_lookup_index), 4);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_wb_mem_write", 32'(a_mem_write), 0);
        chk("rst_wb_lookup_hit", 32'(a_lookup_hit), 0);
        chk("rst_wb_flush_done", 32'(a_flush_done), 1);
        exp_mem_a.delete();
        @(posedge clk); #1 reset_n = 1'b1; a_flush = 1'b0; a_mem_resp = 1'b1;
        @(posedge clk); #1 a_mem_resp = 1'b0;
        @(negedge clk);
        chk("late_resp_mem_write", 32'(a_mem_write), 0);
        chk("late_resp_lookup_hit", 32'(a_lookup_hit), 0);
        a_lookup_addr = 16'h5004;
        do_evict(0, 16'h5000, 0, 0);
        @(negedge clk);
        chk("post_rst_lookup_hit", 32'(a_lookup_hit), 1);
        chk("post_rst_lookup_index", 32'(a_lookup_index), 0);

        chk("arr_a_queue_empty", 32'(exp_arr_a.size()), 0);
        chk("arr_b_queue_empty", 32'(exp_arr_b.size()), 0);
        chk("mem_a_queue_empty", 32'(exp_mem_a.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
